// File: rtl/chain_calculator_if.sv
// Operand beat channel between the keypad/operand front end and the chain calculator.
// The front end is the master and presents one operand beat at a time.
// The calculator is the slave and throttles the front end with in_ready.
interface chain_calculator_if #(
  parameter int IN_W = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_num;
  logic            in_sign;
  logic [1:0]      op;

  modport master (
    output in_valid,
    output in_num,
    output in_sign,
    output op,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_num,
    input  in_sign,
    input  op,
    output in_ready
  );
endinterface

// File: rtl/chain_calculator.sv
// Chained sign-magnitude calculator.
// A load beat seeds the accumulator, then up to MAX_OPS add/sub/mul/div beats
// update it. Results that overflow saturate, and the ovf_flag records it.
// Division uses a restoring divider that produces one quotient bit per cycle.
// Sign convention throughout: 1 = non-negative, 0 = negative.
module chain_calculator #(
  parameter int IN_W    = 4,
  parameter int ACC_W   = 12,
  parameter int MAX_OPS = 4
) (
  input  logic               clk,
  input  logic               rst,
  chain_calculator_if.slave  beat,
  output logic [ACC_W-1:0]   acc_mag,
  output logic               acc_sign,
  output logic               busy,
  output logic               done,
  output logic [3:0]         step_count,
  output logic               zero_flag,
  output logic               ovf_flag,
  output logic               zero_result
);

  localparam int WIDE  = ACC_W + IN_W;
  localparam int CNT_W = $clog2(ACC_W + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam logic [WIDE-1:0]  SAT_WIDE  = WIDE'({ACC_W{1'b1}});
  localparam logic [ACC_W-1:0] SAT_MAG   = {ACC_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(ACC_W - 1);
  localparam logic [3:0]       LAST_STEP = 4'(MAX_OPS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_OP,
    S_DIV,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic             ready;
  logic             fire;
  logic [3:0]       step_inc;
  logic             chain_end;

  logic [WIDE-1:0]  acc_wide;
  logic [WIDE-1:0]  num_wide;
  logic [WIDE-1:0]  raw_mag;
  logic             raw_sign;
  logic             eff_sign;
  logic [ACC_W-1:0] alu_mag;
  logic             alu_sign;
  logic             alu_ovf;

  logic [IN_W-1:0]  divisor;
  logic [IN_W-1:0]  div_rem;
  logic [ACC_W-1:0] div_quot;
  logic [CNT_W-1:0] div_cnt;
  logic             div_sign;
  logic [IN_W:0]    rem_shift;
  logic             q_bit;
  logic [IN_W-1:0]  rem_next;
  logic [ACC_W-1:0] quot_next;
  logic             quot_sign;
  logic             div_last;

  assign beat.in_ready = ready;
  assign fire          = beat.in_valid && ready;
  assign step_inc      = step_count + 4'd1;
  assign chain_end     = (step_inc == LAST_STEP);
  assign zero_result   = (acc_mag == '0);

  // Add/sub/mul result at full width, then saturation and zero-sign normalisation
  always_comb begin
    acc_wide = WIDE'(acc_mag);
    num_wide = WIDE'(beat.in_num);
    eff_sign = (beat.op == OP_SUB) ? ~beat.in_sign : beat.in_sign;
    raw_mag  = '0;
    raw_sign = 1'b1;
    if (beat.op == OP_MUL) begin
      raw_mag  = acc_wide * num_wide;
      raw_sign = ~(acc_sign ^ beat.in_sign);
    end else if (acc_sign == eff_sign) begin
      raw_mag  = acc_wide + num_wide;
      raw_sign = acc_sign;
    end else if (acc_wide >= num_wide) begin
      raw_mag  = acc_wide - num_wide;
      raw_sign = acc_sign;
    end else begin
      raw_mag  = num_wide - acc_wide;
      raw_sign = eff_sign;
    end
    if (raw_mag > SAT_WIDE) begin
      alu_mag = SAT_MAG;
      alu_ovf = 1'b1;
    end else begin
      alu_mag = raw_mag[ACC_W-1:0];
      alu_ovf = 1'b0;
    end
    alu_sign = (alu_mag == '0) ? 1'b1 : raw_sign;
  end

  // One restoring-division step: bring in the next dividend bit, subtract if it fits
  always_comb begin
    rem_shift = {div_rem, div_quot[ACC_W-1]};
    q_bit     = (rem_shift >= {1'b0, divisor});
    rem_next  = q_bit ? IN_W'(rem_shift - {1'b0, divisor}) : IN_W'(rem_shift);
    quot_next = {div_quot[ACC_W-2:0], q_bit};
    quot_sign = (quot_next == '0) ? 1'b1 : div_sign;
    div_last  = (div_cnt == LAST_BIT);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake/status outputs
  always_comb begin
    state_next = state;
    ready      = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (fire) state_next = S_WAIT_OP;
      end
      S_WAIT_OP: begin
        if (fire) begin
          if (beat.op == OP_DIV && beat.in_num != '0) begin
            state_next = S_DIV;
          end else if (chain_end) begin
            state_next = S_DONE;
          end
        end
      end
      S_DIV: begin
        ready = 1'b0;
        busy  = 1'b1;
        if (div_last) state_next = chain_end ? S_DONE : S_WAIT_OP;
      end
      S_DONE: begin
        done = 1'b1;
        if (fire) state_next = S_WAIT_OP;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Accumulator, step counter, sticky flags and divider registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_mag    <= '0;
      acc_sign   <= 1'b1;
      step_count <= '0;
      zero_flag  <= 1'b0;
      ovf_flag   <= 1'b0;
      divisor    <= '0;
      div_rem    <= '0;
      div_quot   <= '0;
      div_cnt    <= '0;
      div_sign   <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (fire) begin
            acc_mag    <= ACC_W'(beat.in_num);
            acc_sign   <= beat.in_sign;
            step_count <= '0;
            zero_flag  <= 1'b0;
            ovf_flag   <= 1'b0;
          end
        end
        S_WAIT_OP: begin
          if (fire) begin
            if (beat.op == OP_DIV) begin
              if (beat.in_num == '0) begin
                acc_mag    <= '0;
                acc_sign   <= 1'b1;
                zero_flag  <= 1'b1;
                step_count <= step_inc;
              end else begin
                divisor  <= beat.in_num;
                div_rem  <= '0;
                div_quot <= acc_mag;
                div_cnt  <= '0;
                div_sign <= ~(acc_sign ^ beat.in_sign);
              end
            end else begin
              acc_mag    <= alu_mag;
              acc_sign   <= alu_sign;
              ovf_flag   <= ovf_flag | alu_ovf;
              step_count <= step_inc;
            end
          end
        end
        S_DIV: begin
          div_rem  <= rem_next;
          div_quot <= quot_next;
          div_cnt  <= div_cnt + 1'b1;
          if (div_last) begin
            acc_mag    <= quot_next;
            acc_sign   <= quot_sign;
            step_count <= step_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chain_calculator.sv
// Self-checking bench for chain_calculator.
// The driver computes each beat's expected result with a signed-integer model
// and queues it; a monitor pops and compares whenever the DUT finishes a step.
module tb_chain_calculator;

  localparam int IN_W    = 4;
  localparam int ACC_W   = 12;
  localparam int MAX_OPS = 4;
  localparam int SAT     = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [ACC_W-1:0] acc_mag;
  logic             acc_sign;
  logic             busy;
  logic             done;
  logic [3:0]       step_count;
  logic             zero_flag;
  logic             ovf_flag;
  logic             zero_result;

  chain_calculator_if #(.IN_W(IN_W)) bus ();

  chain_calculator #(
    .IN_W   (IN_W),
    .ACC_W  (ACC_W),
    .MAX_OPS(MAX_OPS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .beat       (bus),
    .acc_mag    (acc_mag),
    .acc_sign   (acc_sign),
    .busy       (busy),
    .done       (done),
    .step_count (step_count),
    .zero_flag  (zero_flag),
    .ovf_flag   (ovf_flag),
    .zero_result(zero_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    mag;
    int    sign;
    int    step;
    int    zf;
    int    ovf;
    int    done;
    int    busyCycles;
    string tag;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: value held as magnitude plus sign, chain progress and flags
  int mMag, mSign, mStep, mZf, mOvf, mActive;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic resetModel();
    mMag = 0; mSign = 1; mStep = 0; mZf = 0; mOvf = 0; mActive = 0;
  endtask

  // Predict the beat's effect with plain signed arithmetic, queue it, then drive it
  task automatic applyStimulus(input int num, input int sgn, input int opc, input string tag);
    exp_t e;
    int   waited;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput({tag, ".ready_timeout"}, 0, 1);
      return;
    end
    e.busyCycles = 0;
    if (!mActive || mStep == MAX_OPS) begin
      mMag = num; mSign = sgn; mStep = 0; mZf = 0; mOvf = 0; mActive = 1;
    end else begin
      int a, n, v, m;
      a = mSign ? mMag : -mMag;
      n = sgn ? num : -num;
      v = 0;
      if (opc == 2 && n == 0) begin
        mMag = 0; mSign = 1; mZf = 1;
      end else begin
        case (opc)
          0:       v = a + n;
          1:       v = a - n;
          3:       v = a * n;
          default: begin v = a / n; e.busyCycles = ACC_W; end
        endcase
        m = (v < 0) ? -v : v;
        if (m > SAT) begin
          m = SAT;
          mOvf = 1;
        end
        mMag  = m;
        mSign = (v < 0) ? 0 : 1;
      end
      mStep++;
    end
    e.mag = mMag; e.sign = mSign; e.step = mStep; e.zf = mZf; e.ovf = mOvf;
    e.done = (mStep == MAX_OPS) ? 1 : 0;
    e.tag  = tag;
    expQ.push_back(e);
    bus.in_num   = IN_W'(num);
    bus.in_sign  = 1'(sgn);
    bus.op       = 2'(opc);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // While the divider runs the accumulator must hold and the block must refuse beats
  task automatic checkDivHold(input int held, input string tag);
    int bad, n;
    bad = 0;
    n   = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      if (bus.in_ready !== 1'b0 || int'(acc_mag) != held) bad++;
      n++;
      @(negedge clk);
    end
    checkOutput({tag, ".hold_violations"}, bad, 0);
    checkOutput({tag, ".busy_cycles"}, n, ACC_W);
  endtask

  task automatic pulseReset(input string tag);
    int w;
    w = 0;
    while (expQ.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    checkOutput({tag, ".drain_before_reset"}, expQ.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    resetModel();
    expQ.delete();
    rst = 1'b0;
  endtask

  // Monitor: a step completes after an accepted non-dividing beat or when busy falls
  initial begin : monitor
    int   busyRun;
    bit   prevBusy;
    bit   fired;
    exp_t e;
    busyRun  = 0;
    prevBusy = 0;
    fired    = 0;
    forever begin
      @(posedge clk);
      fired = !rst && bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (rst) begin
        busyRun  = 0;
        prevBusy = 0;
      end else begin
        if (busy) begin
          busyRun++;
        end else if (fired || prevBusy) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_output", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput({e.tag, ".acc_mag"},     int'(acc_mag),     e.mag);
            checkOutput({e.tag, ".acc_sign"},    int'(acc_sign),    e.sign);
            checkOutput({e.tag, ".step_count"},  int'(step_count),  e.step);
            checkOutput({e.tag, ".zero_flag"},   int'(zero_flag),   e.zf);
            checkOutput({e.tag, ".ovf_flag"},    int'(ovf_flag),    e.ovf);
            checkOutput({e.tag, ".done"},        int'(done),        e.done);
            checkOutput({e.tag, ".zero_result"}, int'(zero_result), (e.mag == 0) ? 1 : 0);
            checkOutput({e.tag, ".busy_cycles"}, busyRun,           e.busyCycles);
          end
          busyRun = 0;
        end
        prevBusy = busy;
      end
    end
  end

  // Directed scenarios followed by a randomized beat stream
  initial begin : driver
    int w;
    bus.in_valid = 1'b0;
    bus.in_num   = '0;
    bus.in_sign  = 1'b1;
    bus.op       = 2'b00;
    resetModel();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.acc_mag",     int'(acc_mag),     0);
    checkOutput("reset.acc_sign",    int'(acc_sign),    1);
    checkOutput("reset.step_count",  int'(step_count),  0);
    checkOutput("reset.flags",       int'({zero_flag, ovf_flag}), 0);
    checkOutput("reset.busy_done",   int'({busy, done}), 0);
    checkOutput("reset.zero_result", int'(zero_result), 1);
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("reset.in_ready", int'(bus.in_ready), 1);

    applyStimulus(5, 1, 0, "t1_load");
    applyStimulus(7, 0, 0, "t1_add");
    applyStimulus(3, 0, 1, "t1_sub");
    applyStimulus(9, 1, 3, "t1_mul");
    applyStimulus(2, 1, 2, "t1_div");
    applyStimulus(15, 1, 1, "t2_reload");
    applyStimulus(15, 1, 3, "t2_mul1");
    applyStimulus(15, 1, 3, "t2_mul2");
    applyStimulus(15, 1, 3, "t2_mul3");

    pulseReset("t3");
    applyStimulus(9, 0, 0, "t3_load");
    applyStimulus(0, 1, 2, "t3_div0");
    applyStimulus(3, 1, 0, "t3_add");

    pulseReset("t4");
    applyStimulus(13, 1, 0, "t4_load");
    applyStimulus(4, 0, 2, "t4_div");
    checkDivHold(13, "t4_div");

    pulseReset("t5");
    applyStimulus(15, 1, 0, "t5_load");
    applyStimulus(15, 1, 3, "t5_mul1");
    applyStimulus(15, 1, 3, "t5_mul2");
    applyStimulus(2, 1, 2, "t5_div");
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_abort.acc_mag",   int'(acc_mag),  0);
    checkOutput("t5_abort.acc_sign",  int'(acc_sign), 1);
    checkOutput("t5_abort.busy",      int'(busy),     0);
    checkOutput("t5_abort.flags",     int'({zero_flag, ovf_flag}), 0);
    checkOutput("t5_abort.step",      int'(step_count), 0);
    expQ.delete();
    resetModel();
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_abort.in_ready",  int'(bus.in_ready), 1);
    applyStimulus(2, 1, 0, "t5_fresh_load");

    pulseReset("t6");
    applyStimulus(3, 0, 0, "t6_load");
    applyStimulus(3, 1, 0, "t6_add");

    pulseReset("rnd");
    for (int i = 0; i < 80; i++) begin
      int num, sgn, opc;
      num = int'($urandom_range(0, 15));
      sgn = (num == 0) ? 1 : int'($urandom_range(0, 1));
      opc = int'($urandom_range(0, 3));
      applyStimulus(num, sgn, opc, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    w = 0;
    while (expQ.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    checkOutput("final.queue_drain", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chain_calculator.md
Name: chain_calculator

Overview:
- Parametrised, handshaked successor to the 2-bit accumulate calculator.
- Accepts a load operand, then up to MAX_OPS chained operations (add, sub, mul, div) on a sign-magnitude accumulator.
- Signed overflow saturates; division is a multi-cycle restoring divider.
- Sits between the operand/keypad front end and the BCD / seven-segment display path; drives result magnitude, sign and status flags.

Parameters:
- IN_W, 4: operand magnitude width.
- ACC_W, 12: accumulator magnitude width (ACC_W >= IN_W+1).
- MAX_OPS, 4: operations accepted after the load before the chain completes (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_num  in  IN_W  operand magnitude.
- in_sign  in  1  operand sign; 1 = non-negative, 0 = negative (codebase convention).
- op  in  2  00 add, 01 sub, 10 div, 11 mul. Ignored on the load beat.
- acc_mag  out  ACC_W  accumulator magnitude.
- acc_sign  out  1  accumulator sign; same convention as in_sign.
- busy  out  1  division in progress.
- done  out  1  chain complete (MAX_OPS operations executed).
- step_count  out  4  operations executed since the last load.
- zero_flag  out  1  sticky: a division by zero occurred in this chain.
- ovf_flag  out  1  sticky: a result saturated in this chain.
- zero_result  out  1  acc_mag == 0.

Behaviour:
- Reset (async, immediate): state = IDLE, acc_mag = 0, acc_sign = 1, step_count = 0. All flags = 0. in_ready = 1 as soon as rst deasserts.
- Transfer occurs on a rising edge with in_valid & in_ready. in_ready = 1 in IDLE, WAIT_OP and DONE; in_ready = 0 in DIV.
- FSM IDLE:
  - Beat loads acc_mag = zero-extended in_num and acc_sign = in_sign.
  - Clears zero_flag, ovf_flag and step_count.
  - Goes to WAIT_OP.
- FSM WAIT_OP, add/sub/mul beat:
  - Result is registered at that edge (latency 1) and step_count increments.
  - Goes to DONE if step_count reaches MAX_OPS, else stays in WAIT_OP.
- FSM WAIT_OP, div beat:
  - Divisor = 0: result is mag 0, sign 1, zero_flag set, step_count increments. Single cycle; DIV is not entered.
  - Divisor != 0: latches the divisor and enters DIV. busy = 1 for exactly ACC_W cycles, one quotient bit per cycle, MSB first.
  - On the last DIV cycle the quotient is written to acc_mag and step_count increments. Next state is WAIT_OP or DONE, as for the other ops.
  - acc_mag keeps its old value until the quotient is written.
- FSM DONE:
  - done = 1 and outputs are held.
  - A beat is treated as a new load, exactly as in IDLE; done drops the next cycle.
- Add/sub:
  - Sub is add with the operand sign inverted.
  - Same signs: magnitudes add.
  - Different signs: larger minus smaller; sign follows the larger magnitude.
- Mul:
  - Magnitude is acc_mag * in_num, computed at full ACC_W+IN_W width.
  - Sign is XNOR of the two signs.
- Div:
  - Quotient truncates toward zero; sign is XNOR of the two signs; remainder is discarded.
- Saturation: any magnitude > 2^ACC_W-1 clamps to 2^ACC_W-1, keeps the computed sign, and sets ovf_flag.
- Zero normalisation: any zero-magnitude result forces acc_sign = 1. zero_result is combinational from acc_mag.
- zero_flag and ovf_flag stay set until the next load beat or reset.
- Reset during DIV aborts the division; no partial quotient is written.

Test Plan (IN_W=4, ACC_W=12, MAX_OPS=4):
- Chain load +5, add -7, sub -3, mul +9, div +2:
  - Accumulator is -2, then +1, then +9, then +4 (acc_mag=4, acc_sign=1).
  - step_count = 4 and done = 1 the cycle after the div completes.
  - Any further beat reloads.
- Load +15, mul 15, mul 15, mul 15:
  - Accumulator is 225, then 3375, then saturates to 4095 (50625 clamped).
  - ovf_flag = 1 from the saturating step, acc_sign = 1.
- Load -9, div 0, add +3:
  - After the div: mag 0, sign 1, zero_flag = 1, zero_result = 1, busy never high.
  - After the add: +3; zero_flag stays 1.
- Load +13, div -4:
  - in_ready = 0 and busy = 1 for exactly 12 cycles.
  - Result mag 3, sign 0.
  - acc_mag stays 13 until the final DIV edge.
- Reset mid-div: assert rst during DIV cycle 5.
  - acc_mag = 0, acc_sign = 1, busy = 0 and all flags = 0 immediately, before the next edge.
  - in_ready = 1 after release; a fresh load of +2 works.
- Load -3, add +3: mag 0, sign forced to 1, zero_result = 1, ovf_flag = 0.
